// File: rtl/serial_to_par5_pkg.sv
// Shared types and helpers for the serial_to_par5 bit-serial receiver.
package serial_to_par5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 5;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_to_par5_sipo_shreg.sv
// LSB-first serial-in/parallel-out shift register with synchronous clear.
module sipo_shreg #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_to_par5.sv
// Bit-serial receiver: assembles WIDTH LSB-first bits into a word on a valid/ready port.
// Optional build macro PARITY_CHECK_EN adds a trailing even-parity bit and the par_err output.
module serial_to_par5
    import serial_to_par5_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             any_set,
    output logic             busy
`ifdef PARITY_CHECK_EN
    ,
    output logic             par_err
`endif
);

    localparam int CW = cnt_w(WIDTH);
`ifdef PARITY_CHECK_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word;
    logic             go;
    logic             take;
    logic             last;
    logic             shift_en;

    assign take = (state == SHIFT) && ser_valid;
    assign last = take && (cnt == LAST);
    assign go   = start && ((state == IDLE) || ((state == HOLD) && out_ready));

`ifdef PARITY_CHECK_EN
    // The parity bit is consumed but never enters the data register.
    assign shift_en = take && !last;
    assign word     = shreg;
`else
    assign shift_en = take;
    assign word     = {ser_in, shreg[WIDTH-1:1]};
`endif

    sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk (clk),
        .clr (rst || go),
        .en  (shift_en),
        .din (ser_in),
        .q   (shreg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || go) begin
            cnt <= '0;
        end else if (take) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            any_set  <= 1'b0;
        end else if (last) begin
            data_out <= word;
            any_set  <= |word;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (last) begin
            par_err <= (^shreg) ^ ser_in;
        end
    end
`endif

    // HOLD is entered on the same edge that loads data_out, so this is registered.
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_to_par5.sv
// Randomized scoreboard bench for serial_to_par5; builds with or without PARITY_CHECK_EN.
module tb_serial_to_par5;

    localparam int W = 5;
`ifdef PARITY_CHECK_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         a;
        logic         p;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ser_in;
    logic         ser_valid;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         out_ready;
    logic         any_set;
    logic         busy;
`ifdef PARITY_CHECK_EN
    logic         par_err;
`endif

    exp_t q[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    serial_to_par5 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .any_set   (any_set),
        .busy      (busy)
`ifdef PARITY_CHECK_EN
        ,
        .par_err   (par_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bit i of the serial stream is bit i of the word; parity bit follows the data.
    function automatic exp_t model(input logic [NB-1:0] bits);
        exp_t r;
        r.d = '0;
        for (int i = 0; i < W; i++) r.d = r.d + (W'(bits[i]) << i);
        r.a = (r.d != 0);
        r.p = 1'b0;
        for (int i = 0; i < NB; i++) r.p = r.p ^ bits[i];
        return r;
    endfunction

    function automatic logic [NB-1:0] make_bits(input logic [W-1:0] d, input bit bad);
`ifdef PARITY_CHECK_EN
        return {(^d) ^ bad, d};
`else
        return (bad == 1'b0) ? d : d;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("word_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("data_out", data_out, e.d);
                check("any_set", any_set, e.a);
`ifdef PARITY_CHECK_EN
                check("par_err", par_err, e.p);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ser_valid is held high with a 1 on the start cycle; it must be ignored.
    task automatic start_word();
        start = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
        tick();
        start = 1'b0; ser_valid = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    // stall: 0 none, 1 random gaps, 2 one gap between every bit.
    task automatic send_bits(input logic [NB-1:0] bits, input int n, input int stall, input bit push);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && (stall == 2 || (stall == 1 && $urandom_range(0, 1) == 1))) begin
                ser_valid = 1'b0; ser_in = 1'($urandom_range(0, 1));
                tick();
            end
            if (push && i == NB - 1) begin
                q.push_back(model(bits));
                check("valid_before_last", out_valid, 0);
            end
            ser_valid = 1'b1; ser_in = bits[i];
            tick();
        end
        ser_valid = 1'b0;
        if (push) check("valid_latency", out_valid, 1);
    endtask

    task automatic accept(input int hold, input bit nxt, input logic [W-1:0] expd);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            start     = 1'($urandom_range(0, 1));
            ser_valid = 1'($urandom_range(0, 1));
            ser_in    = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0; ser_valid = 1'b0;
        check("hold_valid", out_valid, 1);
        check("hold_data", data_out, expd);
        check("hold_busy", busy, 1);
        out_ready = 1'b1; start = nxt;
        tick();
        out_ready = 1'b0; start = 1'b0;
        check("valid_after_accept", out_valid, 0);
        check("busy_after_accept", busy, nxt);
        check("data_kept", data_out, expd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] d;
        bit           bad;
        bit           nxt;
        bit           shifting;

        rst = 1'b1; start = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_data_out", data_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_any_set", any_set, 0);
        check("rst_busy", busy, 0);
`ifdef PARITY_CHECK_EN
        check("rst_par_err", par_err, 0);
`endif

        for (int i = 0; i < 4; i++) begin
            ser_valid = 1'b1; ser_in = 1'($urandom_range(0, 1));
            tick();
        end
        ser_valid = 1'b0;
        check("idle_out_valid", out_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_data_out", data_out, 0);
        check("idle_any_set", any_set, 0);

        start_word();
        send_bits(make_bits(5'b01010, 1'b0), NB, 0, 1'b1);
        accept(10, 1'b0, 5'b01010);

        start_word();
        send_bits(make_bits(5'b00000, 1'b0), NB, 2, 1'b1);
        accept(2, 1'b0, 5'b00000);

        start_word();
        send_bits(make_bits(5'b11100, 1'b0), NB, 0, 1'b1);
        accept(1, 1'b1, 5'b11100);
        send_bits(make_bits(5'b01101, 1'b0), NB, 0, 1'b1);
        accept(0, 1'b0, 5'b01101);

        start_word();
        send_bits(NB'(5'b10110), 3, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_data_out", data_out, 0);
        tick();
        start_word();
        send_bits(make_bits(5'b11111, 1'b0), NB, 0, 1'b1);
        accept(0, 1'b0, 5'b11111);

`ifdef PARITY_CHECK_EN
        start_word();
        send_bits(make_bits(5'b01101, 1'b0), NB, 0, 1'b1);
        accept(1, 1'b0, 5'b01101);
        start_word();
        send_bits(make_bits(5'b01101, 1'b1), NB, 0, 1'b1);
        accept(1, 1'b0, 5'b01101);
`endif

        shifting = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (!shifting) start_word();
            d   = W'($urandom);
            bad = 1'($urandom_range(0, 1));
            send_bits(make_bits(d, bad), NB, 1, 1'b1);
            nxt = (k < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
            accept($urandom_range(0, 4), nxt, d);
            shifting = nxt;
        end

        tick();
        check("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
